// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Multi-cycle unsigned shift-add multiplier sequencer. It does
//                not contain an adder of its own; each iteration borrows the
//                add path of an external param_ALU instance (operALU=3'b010).
//                An OperandWidth x OperandWidth product is built in
//                OperandWidth iterations, one per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int OperandWidth = 32,
    parameter int CntWidth     = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [OperandWidth-1:0]     multiplicand,
    input  logic [OperandWidth-1:0]     multiplier,
    output logic                        busy,
    output logic                        done,
    output logic [2*OperandWidth-1:0]   product,
    output logic [OperandWidth-1:0]     alu_operandA,
    output logic [OperandWidth-1:0]     alu_operandB,
    output logic [2:0]                  alu_operALU,
    output logic                        alu_carry_in,
    input  logic [OperandWidth-1:0]     alu_result,
    input  logic                        alu_carry_out
);

    // ALU opcode for the plain add path.
    localparam logic [2:0]          C_OP_ADD    = 3'b010;
    // Counter value of the final iteration.
    localparam logic [CntWidth-1:0] C_LAST_ITER = CntWidth'(OperandWidth - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    // acc holds the upper half of the running partial product, q the lower
    // half interleaved with the not-yet-consumed multiplier bits.
    logic [OperandWidth-1:0]    r_acc;
    logic [OperandWidth-1:0]    r_q;
    logic [OperandWidth-1:0]    r_m;
    logic [CntWidth-1:0]        r_cnt;

    logic [OperandWidth-1:0]    w_acc_nxt;
    logic [OperandWidth-1:0]    w_q_nxt;
    logic [OperandWidth-1:0]    w_m_nxt;
    logic [CntWidth-1:0]        w_cnt_nxt;

    // State and datapath registers; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_q     <= w_q_nxt;
            r_m     <= w_m_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and datapath update: load on accepted start, shift-add in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_q_nxt     = r_q;
        w_m_nxt     = r_m;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_m_nxt     = multiplicand;
                    w_q_nxt     = multiplier;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                // The ALU carry becomes the new MSB of acc, so the partial
                // sum never loses bit OperandWidth; the sum LSB drops into q.
                {w_acc_nxt, w_q_nxt} = {alu_carry_out, alu_result, r_q[OperandWidth-1:1]};
                w_cnt_nxt            = r_cnt + CntWidth'(1);
                if (r_cnt == C_LAST_ITER) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                // Back-to-back reload avoids an idle bubble between products.
                if (start) begin
                    w_m_nxt     = multiplicand;
                    w_q_nxt     = multiplier;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status, product and ALU drive decoded from registered state only.
    always_comb begin
        busy         = (r_state == S_RUN);
        done         = (r_state == S_DONE);
        product      = {r_acc, r_q};
        alu_operALU  = C_OP_ADD;
        alu_carry_in = 1'b0;
        alu_operandA = '0;
        alu_operandB = '0;
        if (r_state == S_RUN) begin
            alu_operandA = r_acc;
            alu_operandB = r_q[0] ? r_m : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mul_seq
//  Description : Self-checking bench for alu_mul_seq with a behavioural ALU
//                add path and an arithmetic reference (M*Q).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

    localparam int OW = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [OW-1:0]   multiplicand;
    logic [OW-1:0]   multiplier;
    logic            busy;
    logic            done;
    logic [2*OW-1:0] product;
    logic [OW-1:0]   alu_operandA;
    logic [OW-1:0]   alu_operandB;
    logic [2:0]      alu_operALU;
    logic            alu_carry_in;
    logic [OW-1:0]   alu_result;
    logic            alu_carry_out;

    int              checks   = 0;
    int              failures = 0;
    logic [OW-1:0]   exp_m    = '0;

    alu_mul_seq #(
        .OperandWidth (OW),
        .CntWidth     (6)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .busy          (busy),
        .done          (done),
        .product       (product),
        .alu_operandA  (alu_operandA),
        .alu_operandB  (alu_operandB),
        .alu_operALU   (alu_operALU),
        .alu_carry_in  (alu_carry_in),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out)
    );

    // External ALU add path: {carry_out, result} = A + B + carry_in.
    assign {alu_carry_out, alu_result} = {1'b0, alu_operandA} + {1'b0, alu_operandB}
                                         + {{OW{1'b0}}, alu_carry_in};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // ALU drive contract, observed every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("alu_op", 64'(alu_operALU), 64'h2);
            chk("alu_cin", 64'(alu_carry_in), 64'h0);
            if (busy) begin
                chk("opA_run", 64'(alu_operandA), 64'(product[2*OW-1:OW]));
                chk("opB_run", 64'(alu_operandB), product[0] ? 64'(exp_m) : 64'h0);
            end else begin
                chk("opA_idle", 64'(alu_operandA), 64'h0);
                chk("opB_idle", 64'(alu_operandB), 64'h0);
            end
        end
    end

    // One complete operation from IDLE; returns product seen at done and RUN length.
    task automatic do_op(input logic [OW-1:0] m, input logic [OW-1:0] q, input bit scramble,
                         output logic [63:0] prod, output int nbusy);
        int guard;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        exp_m        = m;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        guard = 0;
        while (!done && guard < 200) begin
            if (busy) nbusy++;
            if (scramble) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            @(negedge clk);
            guard++;
        end
        chk("done_seen", 64'(done), 64'h1);
        prod = product;
        @(negedge clk);
        chk("done_width", 64'(done), 64'h0);
        chk("idle_busy", 64'(busy), 64'h0);
        chk("idle_hold", product, prod);
    endtask

    typedef struct {
        logic [OW-1:0] m;
        logic [OW-1:0] q;
        logic [63:0]   exp;
    } vec_t;

    function automatic logic [OW-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t          vecs[7];
        logic [63:0]   prod;
        int            nbusy;
        int            guard;
        bit            saw_done;
        logic [OW-1:0] rm;
        logic [OW-1:0] rq;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd0,          32'h1234_5678,  64'h0};
        vecs[3] = '{32'd2,          32'd3,          64'd6};
        vecs[4] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vecs[6] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};

        rst_n        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_product", product, 64'h0);
        chk("rst_opA", 64'(alu_operandA), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        foreach (vecs[i]) begin
            do_op(vecs[i].m, vecs[i].q, 1'b1, prod, nbusy);
            chk($sformatf("vec%0d_product", i), prod, vecs[i].exp);
            chk($sformatf("vec%0d_run_cycles", i), 64'(nbusy), 64'd32);
        end

        // Start pulsed mid-RUN is ignored; then start held through DONE reloads.
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd100; multiplier = 32'd200; exp_m = 32'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; multiplicand = 32'd7; multiplier = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("pulse_busy", 64'(busy), 64'h1);
        repeat (8) @(negedge clk);
        start = 1'b1;
        guard = 0;
        while (!done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("b2b_first_done", 64'(done), 64'h1);
        chk("b2b_first_product", product, 64'd20000);
        exp_m = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_gap", 64'(busy), 64'h1);
        chk("b2b_done_width", 64'(done), 64'h0);
        nbusy = 0;
        guard = 0;
        while (!done && guard < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
            guard++;
        end
        chk("b2b_second_done", 64'(done), 64'h1);
        chk("b2b_second_product", product, 64'd49);
        chk("b2b_run_cycles", 64'(nbusy), 64'd32);
        @(negedge clk);

        // Reset asserted mid-RUN aborts asynchronously with no done pulse.
        start = 1'b1; multiplicand = 32'h1234; multiplier = 32'h5678; exp_m = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_abort_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        chk("abort_product", product, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'h0);
        do_op(32'd2, 32'd3, 1'b0, prod, nbusy);
        chk("post_abort_product", prod, 64'd6);

        // Randomised operands against plain multiplication.
        for (int n = 0; n < 1000; n++) begin
            rm = pick();
            rq = pick();
            do_op(rm, rq, 1'b1, prod, nbusy);
            chk($sformatf("rand%0d_%h_x_%h", n, rm, rq), prod, 64'(rm) * 64'(rq));
            chk("rand_run_cycles", 64'(nbusy), 64'd32);
        end

        // Product stays put in IDLE for a while.
        prod = product;
        repeat (5) @(negedge clk);
        chk("idle_long_hold", product, prod);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
